qsfp_reset_sequencer: RTL and testbench
=======================================

QSFP_RESET_SEQUENCER -- requirements
Module: qsfp_reset_sequencer

Interface
REQ-001 SHALL have parameter CH_COUNT, default 2, number of QSFP cages sequenced (1..4).
REQ-002 SHALL have parameter REFCLK_HOLD, default 1024, number of cycles refclk_reset is held after sequence start.
REQ-003 SHALL have parameter MMCM_HOLD, default 1024, number of cycles mmcm_rst is held per attempt.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 65536, number of cycles to wait for lock per attempt.
REQ-005 SHALL have parameter SETTLE, default 16, number of cycles lock must stay high before release.
REQ-006 SHALL have parameter MAX_RETRY, default 3, number of lock attempts before fault.
REQ-007 SHALL have parameter CH_STAGGER, default 256, number of cycles between successive channel reset releases.
REQ-008 SHALL have port clk, input, 1, free-running configuration clock.
REQ-009 SHALL have port reset, input, 1, asynchronous active-low reset; only this port is asynchronous.
REQ-010 SHALL have port restart, input, 1, single-cycle pulse that restarts the sequence.
REQ-011 SHALL have port mmcm_locked, input, 1, asynchronous lock indication.
REQ-012 SHALL have port qsfp_modprsl, input, CH_COUNT, asynchronous active-low module-present signals.
REQ-013 SHALL have port refclk_reset, output, CH_COUNT, active-high clock-generator resets.
REQ-014 SHALL have port mmcm_rst, output, 1, active-high MMCM reset.
REQ-015 SHALL have port sys_rst, output, 1, active-high downstream logic reset.
REQ-016 SHALL have port qsfp_resetl, output, CH_COUNT, active-low module resets.
REQ-017 SHALL have ports ready, output, 1, and fault, output, 1.
REQ-018 SHALL have port retry_count, output, $clog2(MAX_RETRY+1), lock attempts that failed in the current sequence.

Function
REQ-019 SHALL register all outputs; no combinational path from any input to any output.
REQ-020 SHALL synchronise mmcm_locked and each qsfp_modprsl bit through 2 flops; all latencies below count from the synchronised value.
REQ-021 SHALL implement states REFCLK_RST, MMCM_RST, LOCK_WAIT, SETTLE, RUN, FAULT, with one shared down-counter wide enough for the largest parameter.
REQ-022 REFCLK_RST SHALL assert refclk_reset (all bits), mmcm_rst and sys_rst for exactly REFCLK_HOLD cycles, then go to MMCM_RST and deassert refclk_reset.
REQ-023 MMCM_RST SHALL hold mmcm_rst=1 for MMCM_HOLD cycles, then go to LOCK_WAIT with mmcm_rst=0.
REQ-024 LOCK_WAIT SHALL go to SETTLE when lock=1; after LOCK_TIMEOUT cycles without lock it SHALL increment retry_count, then go to FAULT if the new value equals MAX_RETRY, else to MMCM_RST.
REQ-025 SETTLE SHALL go to RUN after lock has been high for SETTLE consecutive cycles; if lock drops, it SHALL go to MMCM_RST without incrementing retry_count.
REQ-026 On entry to RUN, sys_rst SHALL be 0 and ready SHALL be 1.
REQ-027 In RUN, lock loss SHALL go to MMCM_RST; on the next clock edge sys_rst=1 and ready=0.
REQ-028 FAULT SHALL assert mmcm_rst, sys_rst and fault=1, keep refclk_reset=0, and exit only on restart or reset.
REQ-029 restart in any state SHALL go to REFCLK_RST with counter reloaded and retry_count=0; restart SHALL take priority over simultaneous lock events.
REQ-030 Channel i SHALL set qsfp_resetl[i]=1 when RUN entry + (i+1)*CH_STAGGER cycles have elapsed and the module is present.
REQ-031 If a module is removed, its qsfp_resetl[i] SHALL be 0 the next cycle.
REQ-032 If a module is reinserted in RUN, its qsfp_resetl[i] SHALL be 1 exactly CH_STAGGER cycles later, provided it stays present.
REQ-033 Outside RUN, qsfp_resetl SHALL be all 0.
REQ-034 Counter and retry_count SHALL saturate and never wrap.

Reset
REQ-035 While reset=0: state=REFCLK_RST, refclk_reset=all 1, mmcm_rst=1, sys_rst=1, qsfp_resetl=0, ready=0, fault=0, retry_count=0, counter=REFCLK_HOLD.
REQ-036 Reset asserted mid-sequence SHALL abort immediately (asynchronously) to the REQ-035 values; deassertion SHALL restart from REFCLK_RST.

Verification (REFCLK_HOLD=8, MMCM_HOLD=4, LOCK_TIMEOUT=20, SETTLE=3, MAX_RETRY=2, CH_STAGGER=5, CH_COUNT=2)
REQ-037 Release reset with lock rising in LOCK_WAIT and both modules present -> refclk_reset falls after 8 cycles, mmcm_rst falls 4 cycles later, ready=1 after 3 cycles of lock plus sync, qsfp_resetl[0] rises 5 cycles after RUN, qsfp_resetl[1] rises 10 cycles after RUN.
REQ-038 Hold lock=0 -> two 20-cycle timeouts, retry_count goes 1 then 2, fault=1, mmcm_rst=1; restart pulse -> retry_count=0, REFCLK_RST.
REQ-039 Drop lock in RUN -> sys_rst=1 and ready=0 within 3 cycles, qsfp_resetl=0, MMCM_RST re-entered, RUN recovered with retry_count unchanged.
REQ-040 Lock glitch low for 1 cycle during SETTLE -> return to MMCM_RST, retry_count unchanged.
REQ-041 In RUN, remove module 1 then reinsert it -> qsfp_resetl[1]=0 within 3 cycles of removal, =1 exactly 5 cycles after the synchronised reinsert; qsfp_resetl[0] unaffected.
REQ-042 Assert reset in SETTLE, and pulse restart coincident with lock rise in LOCK_WAIT -> REQ-035 values immediately; restart wins over lock (REFCLK_RST).

Source files
------------

// File: rtl/qsfp_reset_sequencer.sv
// QSFP cage power-up reset sequencer: refclk, MMCM lock with retries,
// downstream reset release and staggered per-cage module reset release.
module qsfp_reset_sequencer #(
  parameter int CH_COUNT     = 2,
  parameter int REFCLK_HOLD  = 1024,
  parameter int MMCM_HOLD    = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int SETTLE       = 16,
  parameter int MAX_RETRY    = 3,
  parameter int CH_STAGGER   = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           restart,
  input  logic                           mmcm_locked,
  input  logic [CH_COUNT-1:0]            qsfp_modprsl,
  output logic [CH_COUNT-1:0]            refclk_reset,
  output logic                           mmcm_rst,
  output logic                           sys_rst,
  output logic [CH_COUNT-1:0]            qsfp_resetl,
  output logic                           ready,
  output logic                           fault,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_count
);

  localparam int M1 = (REFCLK_HOLD > MMCM_HOLD) ? REFCLK_HOLD : MMCM_HOLD;
  localparam int M2 = (LOCK_TIMEOUT > SETTLE) ? LOCK_TIMEOUT : SETTLE;
  localparam int MX = (M1 > M2) ? M1 : M2;
  localparam int CW = $clog2(MX + 1);
  localparam int SW = $clog2(CH_COUNT * CH_STAGGER + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    ST_REFCLK_RST,
    ST_MMCM_RST,
    ST_LOCK_WAIT,
    ST_SETTLE,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  last;
  logic [1:0]            lock_q;
  logic                  lock_s;
  logic [CH_COUNT-1:0]   prs_q1;
  logic [CH_COUNT-1:0]   prs_q2;
  logic [CH_COUNT-1:0]   present;
  logic [RW-1:0]         retry_nxt;
  logic [SW-1:0]         ch_cnt [CH_COUNT];

  assign lock_s    = lock_q[1];
  assign present   = ~prs_q2;
  assign last      = (cnt <= CW'(1));
  assign retry_nxt = (retry_count == RW'(MAX_RETRY)) ?
                     retry_count : retry_count + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q <= '0;
      prs_q1 <= '1;
      prs_q2 <= '1;
    end else begin
      lock_q <= {lock_q[0], mmcm_locked};
      prs_q1 <= qsfp_modprsl;
      prs_q2 <= prs_q1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_REFCLK_RST;
      cnt          <= CW'(REFCLK_HOLD);
      refclk_reset <= '1;
      mmcm_rst     <= 1'b1;
      sys_rst      <= 1'b1;
      ready        <= 1'b0;
      fault        <= 1'b0;
      retry_count  <= '0;
    end else if (restart) begin
      state        <= ST_REFCLK_RST;
      cnt          <= CW'(REFCLK_HOLD);
      refclk_reset <= '1;
      mmcm_rst     <= 1'b1;
      sys_rst      <= 1'b1;
      ready        <= 1'b0;
      fault        <= 1'b0;
      retry_count  <= '0;
    end else begin
      unique case (state)
        ST_REFCLK_RST: begin
          if (last) begin
            state        <= ST_MMCM_RST;
            cnt          <= CW'(MMCM_HOLD);
            refclk_reset <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_MMCM_RST: begin
          if (last) begin
            state    <= ST_LOCK_WAIT;
            cnt      <= CW'(LOCK_TIMEOUT);
            mmcm_rst <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_LOCK_WAIT: begin
          if (lock_s) begin
            state <= ST_SETTLE;
            cnt   <= CW'(SETTLE);
          end else if (last) begin
            retry_count <= retry_nxt;
            mmcm_rst    <= 1'b1;
            if (retry_nxt == RW'(MAX_RETRY)) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              state <= ST_MMCM_RST;
              cnt   <= CW'(MMCM_HOLD);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!lock_s) begin
            state    <= ST_MMCM_RST;
            cnt      <= CW'(MMCM_HOLD);
            mmcm_rst <= 1'b1;
          end else if (last) begin
            state   <= ST_RUN;
            sys_rst <= 1'b0;
            ready   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state    <= ST_MMCM_RST;
            cnt      <= CW'(MMCM_HOLD);
            mmcm_rst <= 1'b1;
            sys_rst  <= 1'b1;
            ready    <= 1'b0;
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_REFCLK_RST;
          cnt   <= CW'(REFCLK_HOLD);
        end
      endcase
    end
  end

  // Stagger counters reload outside RUN so RUN entry starts each cage fresh
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qsfp_resetl <= '0;
      for (int i = 0; i < CH_COUNT; i++) ch_cnt[i] <= '0;
    end else if (state != ST_RUN || restart || !lock_s) begin
      qsfp_resetl <= '0;
      for (int i = 0; i < CH_COUNT; i++)
        ch_cnt[i] <= SW'((i + 1) * CH_STAGGER);
    end else begin
      for (int i = 0; i < CH_COUNT; i++) begin
        if (!present[i]) begin
          qsfp_resetl[i] <= 1'b0;
          ch_cnt[i]      <= SW'(CH_STAGGER);
        end else if (!qsfp_resetl[i]) begin
          if (ch_cnt[i] <= SW'(1)) qsfp_resetl[i] <= 1'b1;
          else ch_cnt[i] <= ch_cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qsfp_reset_sequencer.sv
// Directed bench for qsfp_reset_sequencer with randomized timing offsets;
// expected latencies are derived arithmetically from the sequencing rules.
module tb_qsfp_reset_sequencer;

  localparam int RH   = 8;
  localparam int MH   = 4;
  localparam int LT   = 20;
  localparam int ST   = 3;
  localparam int MR   = 2;
  localparam int CS   = 5;
  localparam int CC   = 2;
  localparam int SYNC = 2;

  localparam int W_READY  = 0;
  localparam int W_REFCLK = 1;
  localparam int W_MMCM   = 2;
  localparam int W_FAULT  = 3;
  localparam int W_CH0    = 4;
  localparam int W_CH1    = 5;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         restart;
  logic                         mmcm_locked;
  logic [CC-1:0]                qsfp_modprsl;
  logic [CC-1:0]                refclk_reset;
  logic                         mmcm_rst;
  logic                         sys_rst;
  logic [CC-1:0]                qsfp_resetl;
  logic                         ready;
  logic                         fault;
  logic [$clog2(MR+1)-1:0]      retry_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qsfp_reset_sequencer #(
    .CH_COUNT(CC), .REFCLK_HOLD(RH), .MMCM_HOLD(MH),
    .LOCK_TIMEOUT(LT), .SETTLE(ST), .MAX_RETRY(MR),
    .CH_STAGGER(CS)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .mmcm_locked(mmcm_locked), .qsfp_modprsl(qsfp_modprsl),
    .refclk_reset(refclk_reset), .mmcm_rst(mmcm_rst),
    .sys_rst(sys_rst), .qsfp_resetl(qsfp_resetl),
    .ready(ready), .fault(fault), .retry_count(retry_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      W_READY:  return ready;
      W_REFCLK: return refclk_reset[0];
      W_MMCM:   return mmcm_rst;
      W_FAULT:  return fault;
      W_CH0:    return qsfp_resetl[0];
      default:  return qsfp_resetl[1];
    endcase
  endfunction

  // Negedges until the watched output reaches v; -1 if the bound expires
  task automatic lat(input string tag, input int w, input logic v,
                     input int exp);
    int n;
    int k;
    n = -1;
    k = 0;
    while (n < 0 && k < 200) begin
      @(negedge clk);
      k++;
      if (sel(w) === v) n = k;
    end
    chk(tag, n, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    reset        = 1'b0;
    restart      = 1'b0;
    mmcm_locked  = 1'b0;
    qsfp_modprsl = '0;
    repeat (3) @(negedge clk);
    chk("rst_refclk", refclk_reset, 3);
    chk("rst_mmcm", mmcm_rst, 1);
    chk("rst_sys", sys_rst, 1);
    chk("rst_resetl", qsfp_resetl, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry_count, 0);

    // Power-up sequence with lock arriving at a random point
    reset = 1'b1;
    lat("refclk_hold", W_REFCLK, 1'b0, RH);
    chk("refclk_all_low", refclk_reset, 0);
    chk("mmcm_still_high", mmcm_rst, 1);
    lat("mmcm_hold", W_MMCM, 1'b0, MH);
    d = $urandom_range(0, 10);
    repeat (d) @(negedge clk);
    chk("no_ready_before_lock", ready, 0);
    mmcm_locked = 1'b1;
    lat("ready_up", W_READY, 1'b1, SYNC + 1 + ST);
    chk("run_sys_rst", sys_rst, 0);
    chk("run_retry", retry_count, 0);
    chk("run_resetl_init", qsfp_resetl, 0);
    lat("ch0_up", W_CH0, 1'b1, CS);
    lat("ch1_up", W_CH1, 1'b1, CS);

    // Module 1 pulled and reinserted
    qsfp_modprsl[1] = 1'b1;
    lat("ch1_remove", W_CH1, 1'b0, SYNC + 1);
    chk("ch0_keep_a", qsfp_resetl[0], 1);
    d = $urandom_range(0, 6);
    repeat (d) @(negedge clk);
    qsfp_modprsl[1] = 1'b0;
    lat("ch1_reinsert", W_CH1, 1'b1, SYNC + CS);
    chk("ch0_keep_b", qsfp_resetl[0], 1);

    // Lock loss in RUN and recovery
    mmcm_locked = 1'b0;
    lat("lockloss_ready", W_READY, 1'b0, SYNC + 1);
    chk("lockloss_sys", sys_rst, 1);
    chk("lockloss_resetl", qsfp_resetl, 0);
    chk("lockloss_mmcm", mmcm_rst, 1);
    lat("relock_mmcm_fall", W_MMCM, 1'b0, MH);
    mmcm_locked = 1'b1;
    lat("relock_ready", W_READY, 1'b1, SYNC + 1 + ST);
    chk("relock_retry", retry_count, 0);
    lat("relock_ch0", W_CH0, 1'b1, CS);

    // One-cycle lock glitch while settling
    mmcm_locked = 1'b0;
    lat("glitch_prep_ready", W_READY, 1'b0, SYNC + 1);
    lat("glitch_prep_mmcm", W_MMCM, 1'b0, MH);
    mmcm_locked = 1'b1;
    d = $urandom_range(1, 3);
    repeat (d) @(negedge clk);
    mmcm_locked = 1'b0;
    @(negedge clk);
    mmcm_locked = 1'b1;
    lat("glitch_mmcm", W_MMCM, 1'b1, SYNC);
    chk("glitch_no_ready", ready, 0);
    chk("glitch_retry", retry_count, 0);
    lat("glitch_mmcm_fall", W_MMCM, 1'b0, MH);
    lat("glitch_ready", W_READY, 1'b1, 1 + ST);

    // Lock never returns: two timeouts then fault
    mmcm_locked = 1'b0;
    lat("to_ready_fall", W_READY, 1'b0, SYNC + 1);
    lat("to_mmcm_fall1", W_MMCM, 1'b0, MH);
    lat("timeout1", W_MMCM, 1'b1, LT);
    chk("retry_after_1", retry_count, 1);
    lat("to_mmcm_fall2", W_MMCM, 1'b0, MH);
    lat("timeout2", W_FAULT, 1'b1, LT);
    chk("retry_after_2", retry_count, MR);
    chk("fault_mmcm", mmcm_rst, 1);
    chk("fault_sys", sys_rst, 1);
    chk("fault_refclk", refclk_reset, 0);
    chk("fault_resetl", qsfp_resetl, 0);
    mmcm_locked = 1'b1;
    d = $urandom_range(5, 30);
    repeat (d) @(negedge clk);
    chk("fault_sticky", fault, 1);
    chk("fault_sticky_ready", ready, 0);
    restart     = 1'b1;
    mmcm_locked = 1'b0;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_retry", retry_count, 0);
    chk("restart_fault", fault, 0);
    chk("restart_refclk", refclk_reset, 3);
    chk("restart_mmcm", mmcm_rst, 1);
    lat("restart_refclk_hold", W_REFCLK, 1'b0, RH);
    lat("restart_mmcm_hold", W_MMCM, 1'b0, MH);

    // Asynchronous reset while settling
    mmcm_locked = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_refclk", refclk_reset, 3);
    chk("async_mmcm", mmcm_rst, 1);
    chk("async_sys", sys_rst, 1);
    chk("async_ready", ready, 0);
    chk("async_fault", fault, 0);
    chk("async_retry", retry_count, 0);
    mmcm_locked = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    lat("rerun_refclk_hold", W_REFCLK, 1'b0, RH);
    lat("rerun_mmcm_hold", W_MMCM, 1'b0, MH);

    // Restart arriving on the same edge the lock is first seen
    mmcm_locked = 1'b1;
    repeat (SYNC) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("race_refclk", refclk_reset, 3);
    chk("race_mmcm", mmcm_rst, 1);
    chk("race_ready", ready, 0);
    chk("race_retry", retry_count, 0);
    lat("race_refclk_hold", W_REFCLK, 1'b0, RH);
    lat("race_mmcm_hold", W_MMCM, 1'b0, MH);
    lat("race_ready_up", W_READY, 1'b1, 1 + ST);
    lat("race_ch0", W_CH0, 1'b1, CS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
